// File: rtl/axi_stream_rr_arbiter.sv
// Round-robin, packet-locked AXI-Stream arbiter feeding one registered master output stage.
// Optional macro AXIS_ARB_PKT_COUNT_EN adds per-port completed-packet counters on pkt_count.
module axi_stream_rr_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned ID_WIDTH   = 2
) (
  input  logic                            axi_clk,
  input  logic                            axi_reset,
  input  logic [NUM_PORTS-1:0]            s_axis_valid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_data,
  input  logic [NUM_PORTS-1:0]            s_axis_last,
  output logic [NUM_PORTS-1:0]            s_axis_ready,
  output logic                            m_axis_valid,
  output logic [DATA_WIDTH-1:0]           m_axis_data,
  output logic                            m_axis_last,
  input  logic                            m_axis_ready,
  output logic [ID_WIDTH-1:0]             grant_id,
`ifdef AXIS_ARB_PKT_COUNT_EN
  output logic                            busy,
  output logic [NUM_PORTS*16-1:0]         pkt_count
`else
  output logic                            busy
`endif
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                   state, state_next;
  logic [ID_WIDTH-1:0]      rr_ptr;
  logic [NUM_PORTS-1:0]     grant_oh;
  logic                     g_valid, g_last;
  logic [DATA_WIDTH-1:0]    g_data;
  logic                     out_free, accept;
  logic                     arb_found;
  logic [ID_WIDTH-1:0]      arb_idx;
  logic [2*NUM_PORTS-1:0]   valid_dbl;
  logic [NUM_PORTS-1:0]     valid_rot, scan;
  int unsigned              arb_off, arb_pick;

  assign out_free = !m_axis_valid || m_axis_ready;
  assign grant_oh = NUM_PORTS'(1) << grant_id;
  assign g_valid  = |(s_axis_valid & grant_oh);
  assign g_last   = |(s_axis_last & grant_oh);
  assign g_data   = DATA_WIDTH'(s_axis_data >> (32'(grant_id) * DATA_WIDTH));
  assign accept   = (state == LOCKED) && g_valid && out_free;

  // Rotate so bit 0 is the port just after rr_ptr; the first set bit is the winner.
  assign valid_dbl = {s_axis_valid, s_axis_valid};
  assign valid_rot = NUM_PORTS'(valid_dbl >> (32'(rr_ptr) + 32'd1));

  always_comb begin
    scan      = valid_rot;
    arb_found = 1'b0;
    arb_off   = 0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (!arb_found && scan[0]) begin
        arb_found = 1'b1;
        arb_off   = k;
      end
      scan = scan >> 1;
    end
    arb_pick = 32'(rr_ptr) + 32'd1 + arb_off;
    if (arb_pick >= NUM_PORTS) arb_pick = arb_pick - NUM_PORTS;
    arb_idx = ID_WIDTH'(arb_pick);
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arb_found) state_next = LOCKED;
      LOCKED:  if (accept && g_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_axis_ready = '0;
    busy         = 1'b0;
    if (state == LOCKED) begin
      s_axis_ready = grant_oh & {NUM_PORTS{out_free}};
      busy         = 1'b1;
    end
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      rr_ptr       <= ID_WIDTH'(NUM_PORTS - 1);
      grant_id     <= '0;
      m_axis_valid <= 1'b0;
      m_axis_data  <= '0;
      m_axis_last  <= 1'b0;
    end else begin
      if (state == IDLE && arb_found) grant_id <= arb_idx;
      if (accept && g_last)           rr_ptr   <= grant_id;
      if (accept) begin
        m_axis_valid <= 1'b1;
        m_axis_data  <= g_data;
        m_axis_last  <= g_last;
      end else if (m_axis_ready) begin
        m_axis_valid <= 1'b0;
      end
    end
  end

`ifdef AXIS_ARB_PKT_COUNT_EN
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_pkt_cnt
    logic [15:0] cnt;
    always_ff @(posedge axi_clk or posedge axi_reset) begin
      if (axi_reset)                                          cnt <= '0;
      else if (accept && g_last && grant_id == ID_WIDTH'(i)) cnt <= cnt + 16'd1;
    end
    assign pkt_count[i*16 +: 16] = cnt;
  end
`endif

endmodule

// File: doc/axi_stream_rr_arbiter.md
Name: axi_stream_rr_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares one AXI-Stream master output among NUM_PORTS AXI-Stream slave requesters.
- Sits in front of the loopback/processing datapath so that several sources (e.g. UART-side framer and test-pattern generator) can feed it.
- Grant is held from first beat to the beat carrying last.
- Output is a registered pipeline stage with full throughput while locked.

Parameters:
- DATA_WIDTH, 32, width of each data beat.
- NUM_PORTS, 4, number of slave requesters (2..8).
- ID_WIDTH, 2, width of grant_id; must satisfy 2**ID_WIDTH >= NUM_PORTS.

Ports:
- axi_clk  in  1  clock; all logic on the rising edge.
- axi_reset  in  1  asynchronous, active-high reset.
- s_axis_valid  in  NUM_PORTS  per-requester valid; bit i belongs to port i.
- s_axis_data  in  NUM_PORTS*DATA_WIDTH  port i data is at [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_last  in  NUM_PORTS  per-requester end-of-packet.
- s_axis_ready  out  NUM_PORTS  per-requester ready (combinational).
- m_axis_valid  out  1  registered output valid.
- m_axis_data  out  DATA_WIDTH  registered output data.
- m_axis_last  out  1  registered output last.
- m_axis_ready  in  1  downstream ready.
- grant_id  out  ID_WIDTH  index of the currently or last granted port (registered).
- busy  out  1  1 while in LOCKED.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, rr_ptr=NUM_PORTS-1, so port 0 has first priority.
  - grant_id=0, busy=0, m_axis_valid=0, m_axis_data=0, m_axis_last=0.
- out_free = !m_axis_valid | m_axis_ready.
- State IDLE:
  - s_axis_ready all 0.
  - If any s_axis_valid is set, pick the first set bit scanning rr_ptr+1, rr_ptr+2, … modulo NUM_PORTS.
  - Load grant_id with that index, go to LOCKED, busy=1 next cycle.
  - No valid set: stay in IDLE.
- State LOCKED:
  - s_axis_ready[grant_id] = out_free; all other ready bits are 0.
  - Beat accepted when s_axis_valid[g] & s_axis_ready[g].
  - On accept: m_axis_data <= data[g], m_axis_last <= last[g], m_axis_valid <= 1.
  - On accept with last[g]=1: go to IDLE, rr_ptr <= grant_id.
- Output register, no accept that cycle: if m_axis_ready then m_axis_valid <= 0; otherwise data, last and valid hold (AXI stability).
- Latency: one cycle from accept to m_axis_valid. One IDLE arbitration bubble per packet. Sustained one beat/cycle inside a packet while m_axis_ready=1.
- Granted requester drops valid mid-packet: stay LOCKED, ready still driven, no beat, no timeout. Other requesters wait.
- Single-beat packet (last on first beat): LOCKED for exactly one accepted beat, then IDLE.
- rr_ptr wraps from NUM_PORTS-1 to 0.
- Requesters whose valid asserts while another is locked are not granted until the packet ends.
- Valid bits at indices >= NUM_PORTS cannot exist; grant_id values >= NUM_PORTS never occur.
- Reset mid-packet: immediate return to IDLE. The partial packet is dropped from the output register (m_axis_valid=0). No recovery beat is emitted.
- grant_id holds its value in IDLE until the next arbitration.

Optional Feature:
- Macro: AXIS_ARB_PKT_COUNT_EN.
- Defined:
  - Extra output pkt_count, width NUM_PORTS*16.
  - Field i at [i*16 +: 16] counts accepted last beats from port i.
  - Field wraps 65535 -> 0; reset value 0.
- Not defined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then port 0 sends 3 beats 0x11,0x22,0x33 (last on 0x33), m_axis_ready=1 -> grant_id=0, output 0x11,0x22,0x33 on consecutive cycles, m_axis_last only with 0x33, then busy=0.
- Ports 0..3 all valid, each sending 1-beat packets 0xA0+i, repeated -> output order A0,A1,A2,A3,A0; each grant separated by one IDLE cycle.
- Port 1 locked with a 4-beat packet, port 2 asserts valid at beat 2 -> s_axis_ready[2] stays 0 until after port 1's last is accepted, then port 2 is granted.
- m_axis_ready=0 for 5 cycles mid-packet with data 0xDEADBEEF registered -> m_axis_data and m_axis_valid are stable all 5 cycles, s_axis_ready[g]=0, no beat lost or duplicated.
- Reset asserted in the middle of a 3-beat packet -> m_axis_valid=0 and busy=0 immediately (asynchronous), grant restarts at port 0 after release.
- With AXIS_ARB_PKT_COUNT_EN: 2 packets from port 3 and 1 packet from port 0 -> pkt_count field 3 = 2, field 0 = 1, others 0.
